// File: rtl/imuldiv_result_queue_pkg.sv
// Shared types and helpers for the mul/div result queue.
// Function codes follow the IMULDIV_MULDIVREQ_MSG_FUNC_* encoding used by the mul/div unit.
package imuldiv_result_queue_pkg;

  localparam int unsigned FN_W          = 3;
  localparam int unsigned RESP_W        = 64;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned RESULT_LO_LSB = 0;   // quotient / low product word
  localparam int unsigned RESULT_HI_LSB = 32;  // remainder word
  localparam int unsigned ENTRY_W       = FN_W + WORD_W;

  typedef enum logic [FN_W-1:0] {
    FUNC_MUL  = 3'd0,
    FUNC_DIV  = 3'd1,
    FUNC_DIVU = 3'd2,
    FUNC_REM  = 3'd3,
    FUNC_REMU = 3'd4
  } muldiv_fn_e;

  typedef struct packed {
    logic [FN_W-1:0]   fn;
    logic [WORD_W-1:0] word;
  } result_entry_t;

  // Pick the architecturally visible word; unknown codes fall back to the low word.
  function automatic logic [WORD_W-1:0] select_word(input logic [FN_W-1:0]   fn,
                                                    input logic [RESP_W-1:0] resp);
    logic [WORD_W-1:0] word;
    case (fn)
      FUNC_REM, FUNC_REMU: word = resp[RESULT_HI_LSB +: WORD_W];
      default:             word = resp[RESULT_LO_LSB +: WORD_W];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/imuldiv_result_queue_sync_fifo.sv
// Synchronous val/rdy FIFO with wrap-bit pointers; instantiated for tags and results.
module imuldiv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             full;
  logic             empty;
  logic             enq_fire;
  logic             deq_fire;

  // Occupancy flags from the pointer wrap bit.
  always_comb begin
    empty    = (wptr == rptr);
    full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    enq_rdy  = !full;
    deq_val  = !empty;
    enq_fire = enq_val && !full;
    deq_fire = deq_rdy && !empty;
    deq_data = mem[rptr[AW-1:0]];
  end

  // Storage and pointer update; storage is cleared so the idle head reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (enq_fire) begin
        mem[wptr[AW-1:0]] <= enq_data;
        wptr              <= wptr + PW'(1);
      end
      if (deq_fire) rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/imuldiv_result_queue.sv
// Result queue behind the iterative mul/div unit: pairs request function codes with
// in-order responses, extracts the visible 32-bit word and buffers it for the consumer.
// Optional zero-latency bypass when the result FIFO is empty: IMULDIV_RESULT_QUEUE_BYPASS_EN.
module imuldiv_result_queue
  import imuldiv_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FN_W-1:0]   req_fn,
  input  logic              req_go,
  output logic              tag_rdy,
  input  logic [RESP_W-1:0] muldivresp_msg_result,
  input  logic              muldivresp_val,
  output logic              muldivresp_rdy,
  output logic [WORD_W-1:0] result_msg,
  output logic [FN_W-1:0]   result_fn,
  output logic              result_val,
  input  logic              result_rdy,
  output logic [CW-1:0]     outstanding
);

  logic [FN_W-1:0] tag_head;
  logic            tag_val;
  logic            tag_deq_rdy;
  logic            res_enq_val;
  logic            res_enq_rdy;
  logic            res_deq_val;
  result_entry_t   res_in;
  result_entry_t   res_head;
  result_entry_t   res_out;
  logic            accept;
  logic            bypass;

  imuldiv_sync_fifo #(.WIDTH(FN_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_go),
    .enq_rdy  (tag_rdy),
    .enq_data (req_fn),
    .deq_val  (tag_val),
    .deq_rdy  (tag_deq_rdy),
    .deq_data (tag_head)
  );

  imuldiv_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (res_enq_val),
    .enq_rdy  (res_enq_rdy),
    .enq_data (res_in),
    .deq_val  (res_deq_val),
    .deq_rdy  (result_rdy),
    .deq_data (res_head)
  );

  // Response handshake, word selection and optional bypass steering.
  always_comb begin
    muldivresp_rdy = tag_val && res_enq_rdy;
    tag_deq_rdy    = muldivresp_val && res_enq_rdy;
    accept         = muldivresp_val && muldivresp_rdy;
    res_in.fn      = tag_head;
    res_in.word    = select_word(tag_head, muldivresp_msg_result);
`ifdef IMULDIV_RESULT_QUEUE_BYPASS_EN
    bypass         = accept && !res_deq_val && result_rdy;
`else
    bypass         = 1'b0;
`endif
    res_enq_val    = accept && !bypass;
    res_out        = bypass ? res_in : res_head;
    result_val     = res_deq_val || bypass;
    result_msg     = res_out.word;
    result_fn      = res_out.fn;
  end

  // Tags issued but not yet matched with a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({req_go && tag_rdy, accept})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
